// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback unit.
// Writeback source encodings and default widths.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEM  = 2'd2,
    WB_SRC_X0   = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load results as {rd, data}.
// DEPTH must be a power of two (>= 2); pointers wrap naturally.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // Full blocks a push even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write master: ALU/load arbitration plus pending-write mask.
// Optional WB_TRACE_EN adds source trace and write-count outputs.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid_in,
  output logic                       alu_ready_out,
  input  logic [ADDR_WIDTH-1:0]      alu_rd_in,
  input  logic [DATA_WIDTH-1:0]      alu_data_in,
  input  logic                       mem_valid_in,
  output logic                       mem_ready_out,
  input  logic [ADDR_WIDTH-1:0]      mem_rd_in,
  input  logic [DATA_WIDTH-1:0]      mem_data_in,
  input  logic                       issue_valid_in,
  input  logic [ADDR_WIDTH-1:0]      issue_rd_in,
  output logic                       write_enable_out,
  output logic [ADDR_WIDTH-1:0]      rd_sel_out,
  output logic [DATA_WIDTH-1:0]      write_data_out,
`ifdef WB_TRACE_EN
  output logic [1:0]                 trace_src_out,
  output logic [31:0]                trace_wb_count_out,
`endif
  output logic [2**ADDR_WIDTH-1:0]   pending_mask_out
);

  localparam int NREG = 2**ADDR_WIDTH;
  localparam int EW   = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW   = $clog2(MEM_FIFO_DEPTH) + 1;

  logic [EW-1:0]         f_head;
  logic                  f_full;
  logic                  f_empty;
  logic [CW-1:0]         f_count;
  logic                  f_push;
  logic                  f_pop;

  logic                  sel_alu;
  logic                  sel_mem;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  wb_src_e               src_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NREG-1:0]       mask_q, mask_d;
  logic [NREG-1:0]       set_v;
  logic [NREG-1:0]       clr_v;

  assign mem_ready_out = (f_count < CW'(MEM_FIFO_DEPTH));
  assign alu_ready_out = !f_full;
  assign f_push        = mem_valid_in && mem_ready_out;
  assign f_pop         = sel_mem;

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (f_push),
    .wdata_i ({mem_rd_in, mem_data_in}),
    .pop_i   (f_pop),
    .rdata_o (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  // A full FIFO drains first so loads cannot starve behind the ALU.
  always_comb begin
    sel_alu  = 1'b0;
    sel_mem  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (f_full) begin
      sel_mem = 1'b1;
    end else if (alu_valid_in) begin
      sel_alu = 1'b1;
    end else if (!f_empty) begin
      sel_mem = 1'b1;
    end
    if (sel_mem) begin
      sel_rd   = f_head[EW-1:DATA_WIDTH];
      sel_data = f_head[DATA_WIDTH-1:0];
    end else if (sel_alu) begin
      sel_rd   = alu_rd_in;
      sel_data = alu_data_in;
    end
  end

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    src_d  = WB_SRC_NONE;
    set_v  = '0;
    clr_v  = '0;
    if (sel_alu || sel_mem) begin
      we_d   = (sel_rd != '0);
      rd_d   = sel_rd;
      data_d = sel_data;
      src_d  = !we_d  ? WB_SRC_X0 :
               sel_alu ? WB_SRC_ALU : WB_SRC_MEM;
    end
    if (we_d) clr_v[sel_rd] = 1'b1;
    if (issue_valid_in && issue_rd_in != '0) set_v[issue_rd_in] = 1'b1;
    mask_d    = (mask_q & ~clr_v) | set_v;
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign write_enable_out = we_q;
  assign rd_sel_out       = rd_q;
  assign write_data_out   = data_q;
  assign pending_mask_out = mask_q;

`ifdef WB_TRACE_EN
  logic [1:0]  src_q;
  logic [31:0] wbcnt_q, wbcnt_d;

  assign wbcnt_d = wbcnt_q + (we_q ? 32'd1 : 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= WB_SRC_NONE;
      wbcnt_q <= '0;
    end else begin
      src_q   <= src_d;
      wbcnt_q <= wbcnt_d;
    end
  end

  assign trace_src_out      = src_q;
  assign trace_wb_count_out = wbcnt_q;
`else
  wb_src_e unused_src;
  assign unused_src = src_d;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, then random
// traffic against a queue-based reference model.
module tb_writeback_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid_in;
  logic        alu_ready_out;
  logic [4:0]  alu_rd_in;
  logic [31:0] alu_data_in;
  logic        mem_valid_in;
  logic        mem_ready_out;
  logic [4:0]  mem_rd_in;
  logic [31:0] mem_data_in;
  logic        issue_valid_in;
  logic [4:0]  issue_rd_in;
  logic        write_enable_out;
  logic [4:0]  rd_sel_out;
  logic [31:0] write_data_out;
  logic [31:0] pending_mask_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_unit #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (5),
    .MEM_FIFO_DEPTH (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid_in     (alu_valid_in),
    .alu_ready_out    (alu_ready_out),
    .alu_rd_in        (alu_rd_in),
    .alu_data_in      (alu_data_in),
    .mem_valid_in     (mem_valid_in),
    .mem_ready_out    (mem_ready_out),
    .mem_rd_in        (mem_rd_in),
    .mem_data_in      (mem_data_in),
    .issue_valid_in   (issue_valid_in),
    .issue_rd_in      (issue_rd_in),
    .write_enable_out (write_enable_out),
    .rd_sel_out       (rd_sel_out),
    .write_data_out   (write_data_out),
    .pending_mask_out (pending_mask_out)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        iv;
    logic [4:0]  ird;
    logic        chk_rdy;
    logic        ear;
    logic        emr;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] edat;
    logic [31:0] emask;
  } vec_t;

  function automatic vec_t mk(
    logic rst, logic av, logic [4:0] ard, logic [31:0] adat,
    logic mv, logic [4:0] mrd, logic [31:0] mdat,
    logic iv, logic [4:0] ird, logic chk_rdy, logic ear, logic emr,
    logic ewe, logic [4:0] erd, logic [31:0] edat, logic [31:0] emask);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.iv = iv; v.ird = ird; v.chk_rdy = chk_rdy;
    v.ear = ear; v.emr = emr; v.ewe = ewe;
    v.erd = erd; v.edat = edat; v.emask = emask;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic mv,
                       input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic iv, input logic [4:0] ird);
    reset          = rst;
    alu_valid_in   = av;
    alu_rd_in      = ard;
    alu_data_in    = adat;
    mem_valid_in   = mv;
    mem_rd_in      = mrd;
    mem_data_in    = mdat;
    issue_valid_in = iv;
    issue_rd_in    = ird;
  endtask

  vec_t vt[19];

  // Reference model state
  logic [36:0] q[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_mask;

  initial begin
    vt[0]  = mk(1,0,0,0, 0,0,0, 0,0, 0,1,1, 0,0,0,0);
    vt[1]  = mk(0,1,5,32'hDEADBEEF, 0,0,0, 0,0, 1,1,1, 1,5,32'hDEADBEEF,0);
    vt[2]  = mk(0,0,0,0, 0,0,0, 1,7, 1,1,1, 0,0,0,32'h80);
    vt[3]  = mk(0,0,0,0, 1,7,32'h12, 0,0, 1,1,1, 0,0,0,32'h80);
    vt[4]  = mk(0,0,0,0, 0,0,0, 0,0, 1,1,1, 1,7,32'h12,0);
    vt[5]  = mk(0,1,0,32'hFFFFFFFF, 0,0,0, 0,0, 1,1,1, 0,0,0,0);
    vt[6]  = mk(0,0,0,0, 0,0,0, 1,9, 1,1,1, 0,0,0,32'h200);
    vt[7]  = mk(0,1,9,32'h99, 0,0,0, 1,9, 1,1,1, 1,9,32'h99,32'h200);
    vt[8]  = mk(0,1,3,32'h33, 1,1,32'h11, 0,0, 1,1,1, 1,3,32'h33,32'h200);
    vt[9]  = mk(0,1,4,32'h44, 1,2,32'h22, 0,0, 1,1,1, 1,4,32'h44,32'h200);
    vt[10] = mk(0,1,6,32'h66, 0,0,0, 0,0, 1,0,0, 1,1,32'h11,32'h200);
    vt[11] = mk(0,1,6,32'h66, 0,0,0, 0,0, 1,1,1, 1,6,32'h66,32'h200);
    vt[12] = mk(0,0,0,0, 0,0,0, 0,0, 1,1,1, 1,2,32'h22,32'h200);
    vt[13] = mk(0,1,12,32'hC, 1,10,32'hA, 0,0, 1,1,1, 1,12,32'hC,32'h200);
    vt[14] = mk(0,1,13,32'hD, 1,11,32'hB, 0,0, 1,1,1, 1,13,32'hD,32'h200);
    vt[15] = mk(1,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,0);
    vt[16] = mk(0,0,0,0, 0,0,0, 1,0, 1,1,1, 0,0,0,0);
    vt[17] = mk(0,0,0,0, 0,0,0, 0,0, 1,1,1, 0,0,0,0);
    vt[18] = mk(0,0,0,0, 0,0,0, 0,0, 1,1,1, 0,0,0,0);

    drive(1,0,0,0,0,0,0,0,0);

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].av, vt[i].ard, vt[i].adat, vt[i].mv,
            vt[i].mrd, vt[i].mdat, vt[i].iv, vt[i].ird);
      #1;
      if (vt[i].chk_rdy) begin
        chk($sformatf("v%0d alu_ready", i), 32'(alu_ready_out), 32'(vt[i].ear));
        chk($sformatf("v%0d mem_ready", i), 32'(mem_ready_out), 32'(vt[i].emr));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d we", i), 32'(write_enable_out), 32'(vt[i].ewe));
      if (vt[i].ewe || vt[i].rst) begin
        chk($sformatf("v%0d rd", i), 32'(rd_sel_out), 32'(vt[i].erd));
        chk($sformatf("v%0d data", i), write_data_out, vt[i].edat);
      end
      chk($sformatf("v%0d mask", i), pending_mask_out, vt[i].emask);
      @(negedge clk);
    end

    // Random traffic, model starts from the reset state
    begin
      logic        rst, av, mv, iv, full;
      logic [4:0]  ard, mrd, ird;
      logic [31:0] adat, mdat;
      logic        sel;
      logic [36:0] e;
      rst = 1'b1; av = 0; mv = 0; ard = 0; mrd = 0; adat = 0; mdat = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c > 0) rst = ($urandom_range(0, 199) == 0);
        iv  = ($urandom_range(0, 2) == 0);
        ird = 5'($urandom_range(0, 31));
        drive(rst, av, ard, adat, mv, mrd, mdat, iv, ird);
        full = (q.size() == D);
        #1;
        chk("rnd alu_ready", 32'(alu_ready_out), 32'(!full));
        chk("rnd mem_ready", 32'(mem_ready_out), 32'(!full));
        if (rst) begin
          q.delete();
          m_we = 0; m_rd = 0; m_data = 0; m_mask = 0;
        end else begin
          sel = 1'b1;
          if (full)              e = q.pop_front();
          else if (av)           e = {ard, adat};
          else if (q.size() > 0) e = q.pop_front();
          else                   sel = 1'b0;
          m_we = sel && (e[36:32] != 0);
          if (m_we) begin
            m_rd   = e[36:32];
            m_data = e[31:0];
            m_mask[m_rd] = 1'b0;
          end
          if (iv && ird != 0) m_mask[ird] = 1'b1;
          if (mv && !full) q.push_back({mrd, mdat});
        end
        @(posedge clk);
        #1;
        chk("rnd we", 32'(write_enable_out), 32'(m_we));
        if (m_we || rst) begin
          chk("rnd rd", 32'(rd_sel_out), 32'(m_rd));
          chk("rnd data", write_data_out, m_data);
        end
        chk("rnd mask", pending_mask_out, m_mask);
        // Producers hold a result until it is accepted
        if (rst || !av || !full) begin
          av   = ($urandom_range(0, 1) == 0);
          ard  = 5'($urandom_range(0, 31));
          adat = $urandom;
        end
        if (rst || !mv || !full) begin
          mv   = ($urandom_range(0, 2) == 0);
          mrd  = 5'($urandom_range(0, 31));
          mdat = $urandom;
        end
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side master for the 32-entry CPU register file. It merges results from the ALU path and the load (memory) path into a single registered write port (write_enable / rd / data).
- Buffers load results in a small FIFO and arbitrates between the two sources.
- Keeps a pending-write scoreboard so the issue logic can detect RAW hazards on registers still awaiting writeback.

Parameters:
- DATA_WIDTH, 32, width of register data.
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- MEM_FIFO_DEPTH, 2, load-result buffer depth; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid_in  in  1  ALU result present this cycle.
- alu_ready_out  out  1  ALU result accepted this cycle (combinational).
- alu_rd_in  in  ADDR_WIDTH  ALU destination register.
- alu_data_in  in  DATA_WIDTH  ALU result.
- mem_valid_in  in  1  load result present.
- mem_ready_out  out  1  FIFO can accept a load result (combinational).
- mem_rd_in  in  ADDR_WIDTH  load destination register.
- mem_data_in  in  DATA_WIDTH  load data.
- issue_valid_in  in  1  an instruction writing issue_rd_in is issued.
- issue_rd_in  in  ADDR_WIDTH  destination of the issued instruction.
- write_enable_out  out  1  register file write enable (registered).
- rd_sel_out  out  ADDR_WIDTH  register file write index (registered).
- write_data_out  out  DATA_WIDTH  register file write data (registered).
- pending_mask_out  out  2**ADDR_WIDTH  bit i = register i has an outstanding write (registered).

Behaviour:
- Reset: write_enable_out=0, rd_sel_out=0, write_data_out=0, pending_mask_out=0, FIFO emptied. mem_ready_out=1 and alu_ready_out=1 in the first post-reset cycle.
- Handshakes:
  - Load transfer occurs when mem_valid_in && mem_ready_out.
  - ALU transfer occurs when alu_valid_in && alu_ready_out.
  - A producer holds rd/data stable while valid && !ready.
- mem_ready_out = (fifo_count < MEM_FIFO_DEPTH). No push-when-full, even if a pop happens the same cycle.
- Arbitration, evaluated each cycle:
  - If the FIFO is full: pop the FIFO head to the output and set alu_ready_out=0.
  - Else if alu_valid_in: ALU to the output; alu_ready_out=1.
  - Else if the FIFO is non-empty: pop the head to the output.
  - Else: write_enable_out=0 next cycle. rd_sel_out and write_data_out hold their previous values.
- alu_ready_out = !fifo_full (independent of alu_valid_in).
- Push and pop in the same cycle: count is unchanged.
- A load pushed this cycle cannot be popped the same cycle. Minimum load-to-write latency is 2 cycles; ALU-to-write latency is 1 cycle.
- Order: load results retire in arrival order. No ordering guarantee exists between the ALU and load streams; issue logic relies on pending_mask_out.
- Register x0:
  - A selected result with rd==0 is consumed but produces write_enable_out=0.
  - rd==0 never sets or clears a pending bit.
- FIFO pointers wrap modulo MEM_FIFO_DEPTH. Count width is clog2(DEPTH)+1.
- Scoreboard, per register i != 0:
  - Set when issue_valid_in && issue_rd_in==i.
  - Cleared when a write to i is selected for the output register.
  - Simultaneous set and clear of the same i: the bit stays set (set wins).
- Reset mid-operation discards buffered loads and all pending bits. No write is emitted in the cycle following reset.

Optional Feature:
- Macro: WB_TRACE_EN.
- When defined, add two outputs:
  - trace_src_out, 2 bits, registered: 0=none, 1=ALU, 2=MEM, 3=dropped x0.
  - trace_wb_count_out, 32 bits: counts cycles with write_enable_out=1, wraps at 2**32, cleared by reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - WB_SRC_NONE/ALU/MEM/X0 encodings (2-bit typedef).
  - Default DATA_WIDTH/ADDR_WIDTH constants.
- One sub-module, wb_fifo:
  - Parameterised DEPTH/width synchronous FIFO storing {rd, data}.
  - Outputs full, empty and count; same reset semantics.
- Arbiter and scoreboard stay in writeback_unit.

Test Plan:
- Reset, then ALU valid rd=5 data=0xDEADBEEF -> next cycle: write_enable_out=1, rd_sel_out=5, write_data_out=0xDEADBEEF; alu_ready_out=1 throughout.
- issue rd=7, then load rd=7 data=0x12 with no ALU traffic -> pending bit 7 high from the cycle after issue; write appears 2 cycles after the load handshake; bit 7 clears at the same edge as the write.
- Two loads (rd=1, rd=2) back-to-back while ALU is valid every cycle -> after the 2nd push the FIFO is full: mem_ready_out=0 and alu_ready_out=0. Rd=1 and then rd=2 are written; the ALU resumes once the FIFO is not full.
- ALU result with rd=0 and data=0xFFFFFFFF -> write_enable_out stays 0; pending_mask_out[0] stays 0.
- issue rd=9 in the same cycle that a pending rd=9 ALU write is selected -> bit 9 remains 1.
- Fill the FIFO, assert reset for 1 cycle -> mask=0, mem_ready_out=1, write_enable_out=0; no buffered load is ever written.
